// File: rtl/add_hold_pkg.sv
// add_hold_pkg: shared types, bus precharge constant and BCD correction for the adder hold register.
// The correction is only used when DECIMAL_ADJ_EN is defined.
package add_hold_pkg;
    localparam int DEF_WIDTH = 8;
    localparam logic [63:0] BUS_PRECHARGE = '1;

    typedef struct packed {
        logic [DEF_WIDTH-1:0] data;
        logic                 c;
        logic                 v;
    } hold_entry_t;

    function automatic logic [7:0] dec_adjust(input logic [7:0] d, input logic daa, input logic dsa,
                                              input logic hc, input logic c);
        logic [7:0] w_up;
        logic [7:0] w_dn;
        w_up = (c ? 8'h60 : 8'h00) | (hc ? 8'h06 : 8'h00);
        w_dn = (c ? 8'h00 : 8'h60) | (hc ? 8'h00 : 8'h06);
        return (daa && !dsa) ? d + w_up : (dsa && !daa) ? d - w_dn : d;
    endfunction
endpackage

// File: rtl/add_hold_stack.sv
// add_hold_stack: DEPTH-entry history stack; a push when full drops the oldest entry.
// Independent of DECIMAL_ADJ_EN.
module add_hold_stack #(
    parameter int DEPTH = 2,
    parameter int EW    = 10,
    parameter int HW    = $clog2(DEPTH + 1)
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_push,
    input  logic          i_pop,
    input  logic [EW-1:0] i_data,
    output logic [EW-1:0] o_top,
    output logic [HW-1:0] o_count,
    output logic          o_empty
);
    localparam logic [HW-1:0] FULL = HW'(DEPTH);

    logic [EW-1:0] r_mem [2**HW];
    logic [HW-1:0] r_count;
    logic          w_full;
    logic [HW-1:0] w_top_idx;

    assign w_full    = r_count == FULL;
    assign w_top_idx = r_count - 1'b1;
    assign o_empty   = r_count == '0;
    assign o_top     = r_mem[w_top_idx];
    assign o_count   = r_count;

    // Oldest entry lives at index 0, so overflow is a shift toward 0.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= '0;
            for (int i = 0; i < 2**HW; i++) r_mem[i] <= '0;
        end else if (i_push) begin
            if (w_full) begin
                for (int i = 0; i < DEPTH - 1; i++) r_mem[i] <= r_mem[i+1];
                r_mem[DEPTH-1] <= i_data;
            end else begin
                r_mem[r_count] <= i_data;
                r_count        <= r_count + 1'b1;
            end
        end else if (i_pop && !o_empty) begin
            r_count <= r_count - 1'b1;
        end
    end
endmodule

// File: rtl/add_hold_reg_n.sv
// add_hold_reg_n: ALU result hold register with history and registered ADL/split-SB drivers.
// Define DECIMAL_ADJ_EN to add DAA/DSA/ALU_HC and BCD-correct data on load (WIDTH must be 8).
module add_hold_reg_n
    import add_hold_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int SB_SPLIT = 7,
    parameter int DEPTH    = 2,
    parameter int HW       = $clog2(DEPTH + 1)
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             ALU_LOAD,
    input  logic [WIDTH-1:0] ALU_DATA,
    input  logic             ALU_COUT,
    input  logic             ALU_OVF,
`ifdef DECIMAL_ADJ_EN
    input  logic             DAA,
    input  logic             DSA,
    input  logic             ALU_HC,
`endif
    input  logic             RESTORE,
    input  logic             ADL_BUS_ENABLE,
    input  logic             SB_L_BUS_ENABLE,
    input  logic             SB_H_BUS_ENABLE,
    output logic [WIDTH-1:0] ADL_BUS,
    output logic [WIDTH-1:0] SB_BUS,
    output logic             HOLD_C,
    output logic             HOLD_V,
    output logic [HW-1:0]    HIST_COUNT,
    output logic             RESTORE_ERR
);
    localparam int EW = WIDTH + 2;

    logic [WIDTH-1:0] r_hold;
    logic             r_c;
    logic             r_v;
    logic             r_err;
    logic [WIDTH-1:0] r_adl;
    logic [WIDTH-1:0] r_sb;
    logic [WIDTH-1:0] w_load_data;
    logic [EW-1:0]    w_top;
    logic             w_empty;
    logic             w_pop;

`ifdef DECIMAL_ADJ_EN
    if (WIDTH != 8) begin : g_width_check
        $error("add_hold_reg_n: DECIMAL_ADJ_EN requires WIDTH == 8");
    end
    assign w_load_data = dec_adjust(ALU_DATA, DAA, DSA, ALU_HC, ALU_COUT);
`else
    assign w_load_data = ALU_DATA;
`endif

    assign w_pop = RESTORE && !ALU_LOAD;

    add_hold_stack #(.DEPTH(DEPTH), .EW(EW), .HW(HW)) u_stack (
        .i_clk   (CLK),
        .i_rst_n (RST_N),
        .i_push  (ALU_LOAD),
        .i_pop   (w_pop),
        .i_data  ({r_hold, r_c, r_v}),
        .o_top   (w_top),
        .o_count (HIST_COUNT),
        .o_empty (w_empty)
    );

    // Bus drivers copy the pre-edge hold value, so load-and-drive shows the old result.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_hold <= '0;
            r_c    <= 1'b0;
            r_v    <= 1'b0;
            r_err  <= 1'b0;
            r_adl  <= BUS_PRECHARGE[WIDTH-1:0];
            r_sb   <= BUS_PRECHARGE[WIDTH-1:0];
        end else begin
            if (ALU_LOAD) {r_hold, r_c, r_v} <= {w_load_data, ALU_COUT, ALU_OVF};
            else if (w_pop && !w_empty) {r_hold, r_c, r_v} <= w_top;
            r_err <= w_pop && w_empty;
            if (ADL_BUS_ENABLE) r_adl <= r_hold;
            if (SB_L_BUS_ENABLE) r_sb[SB_SPLIT-1:0] <= r_hold[SB_SPLIT-1:0];
            if (SB_H_BUS_ENABLE) r_sb[WIDTH-1:SB_SPLIT] <= r_hold[WIDTH-1:SB_SPLIT];
        end
    end

    assign ADL_BUS     = r_adl;
    assign SB_BUS      = r_sb;
    assign HOLD_C      = r_c;
    assign HOLD_V      = r_v;
    assign RESTORE_ERR = r_err;
endmodule

// File: tb/tb_add_hold_reg_n.sv
// tb_add_hold_reg_n: directed scenarios plus a random run against a queue-based model.
// Decimal-correction checks are compiled only when DECIMAL_ADJ_EN is defined.
module tb_add_hold_reg_n;
    localparam int DEPTH = 2;

    logic       CLK = 0, RST_N = 0;
    logic       ALU_LOAD = 0, ALU_COUT = 0, ALU_OVF = 0, RESTORE = 0;
    logic [7:0] ALU_DATA = 0;
    logic       ADL_BUS_ENABLE = 0, SB_L_BUS_ENABLE = 0, SB_H_BUS_ENABLE = 0;
`ifdef DECIMAL_ADJ_EN
    logic       DAA = 0, DSA = 0, ALU_HC = 0;
`endif
    logic [7:0] ADL_BUS, SB_BUS;
    logic       HOLD_C, HOLD_V, RESTORE_ERR;
    logic [1:0] HIST_COUNT;

    int errors = 0;
    int checks = 0;

    add_hold_reg_n #(.WIDTH(8), .SB_SPLIT(7), .DEPTH(DEPTH)) dut (
        .CLK(CLK), .RST_N(RST_N),
        .ALU_LOAD(ALU_LOAD), .ALU_DATA(ALU_DATA), .ALU_COUT(ALU_COUT), .ALU_OVF(ALU_OVF),
`ifdef DECIMAL_ADJ_EN
        .DAA(DAA), .DSA(DSA), .ALU_HC(ALU_HC),
`endif
        .RESTORE(RESTORE), .ADL_BUS_ENABLE(ADL_BUS_ENABLE),
        .SB_L_BUS_ENABLE(SB_L_BUS_ENABLE), .SB_H_BUS_ENABLE(SB_H_BUS_ENABLE),
        .ADL_BUS(ADL_BUS), .SB_BUS(SB_BUS), .HOLD_C(HOLD_C), .HOLD_V(HOLD_V),
        .HIST_COUNT(HIST_COUNT), .RESTORE_ERR(RESTORE_ERR)
    );

    always #5 CLK = ~CLK;

    task automatic cyc(input logic ld, input logic [7:0] d, input logic c, input logic v,
                       input logic rs, input logic adl, input logic sbl, input logic sbh);
        ALU_LOAD = ld; ALU_DATA = d; ALU_COUT = c; ALU_OVF = v; RESTORE = rs;
        ADL_BUS_ENABLE = adl; SB_L_BUS_ENABLE = sbl; SB_H_BUS_ENABLE = sbh;
        @(posedge CLK);
        #1;
        ALU_LOAD = 0; RESTORE = 0; ADL_BUS_ENABLE = 0; SB_L_BUS_ENABLE = 0; SB_H_BUS_ENABLE = 0;
    endtask

    task automatic do_reset;
        @(negedge CLK);
        RST_N = 0;
        @(negedge CLK);
        RST_N = 1;
    endtask

    task automatic test_reset;
        do_reset();
        cyc(1, 8'h5A, 1, 1, 0, 0, 0, 0);
        cyc(0, 8'h00, 0, 0, 0, 1, 1, 1);
        @(negedge CLK);
        #2;
        RST_N = 0;
        #1;
        checks++; if (ADL_BUS !== 8'hFF) begin errors++; $display("FAIL rst_adl got %h want ff", ADL_BUS); end
        checks++; if (SB_BUS !== 8'hFF) begin errors++; $display("FAIL rst_sb got %h want ff", SB_BUS); end
        checks++; if (HIST_COUNT !== 2'd0) begin errors++; $display("FAIL rst_count got %0d want 0", HIST_COUNT); end
        checks++; if ({HOLD_C, HOLD_V, RESTORE_ERR} !== 3'b000) begin errors++; $display("FAIL rst_flags got %b want 000", {HOLD_C, HOLD_V, RESTORE_ERR}); end
        @(negedge CLK);
        RST_N = 1;
        cyc(0, 8'h00, 0, 0, 0, 1, 0, 0);
        checks++; if (ADL_BUS !== 8'h00) begin errors++; $display("FAIL rst_hold_adl got %h want 00", ADL_BUS); end
    endtask

    task automatic test_load_drive;
        cyc(1, 8'hFF, 1, 0, 0, 1, 0, 0);
        checks++; if (ADL_BUS !== 8'h00) begin errors++; $display("FAIL same_cycle_adl got %h want 00", ADL_BUS); end
        cyc(0, 8'h00, 0, 0, 0, 1, 0, 0);
        checks++; if (ADL_BUS !== 8'hFF) begin errors++; $display("FAIL next_cycle_adl got %h want ff", ADL_BUS); end
        checks++; if (HOLD_C !== 1'b1) begin errors++; $display("FAIL hold_c got %b want 1", HOLD_C); end
    endtask

    task automatic test_sb_split;
        cyc(0, 8'h00, 0, 0, 0, 0, 1, 0);
        checks++; if (SB_BUS !== 8'hFF) begin errors++; $display("FAIL sb_low got %h want ff", SB_BUS); end
        cyc(1, 8'h00, 0, 0, 0, 0, 0, 0);
        cyc(0, 8'h00, 0, 0, 0, 0, 0, 1);
        checks++; if (SB_BUS !== 8'h7F) begin errors++; $display("FAIL sb_high got %h want 7f", SB_BUS); end
        checks++; if (ADL_BUS !== 8'hFF) begin errors++; $display("FAIL adl_retain got %h want ff", ADL_BUS); end
        cyc(0, 8'h00, 0, 0, 0, 0, 1, 0);
        checks++; if (SB_BUS !== 8'h00) begin errors++; $display("FAIL sb_low2 got %h want 00", SB_BUS); end
    endtask

    task automatic test_history;
        do_reset();
        cyc(1, 8'h12, 0, 0, 0, 0, 0, 0);
        cyc(1, 8'h34, 0, 0, 0, 0, 0, 0);
        cyc(1, 8'h56, 0, 0, 0, 0, 0, 0);
        checks++; if (HIST_COUNT !== 2'd2) begin errors++; $display("FAIL hist_full got %0d want 2", HIST_COUNT); end
        cyc(0, 8'h00, 0, 0, 1, 0, 0, 0);
        checks++; if (HIST_COUNT !== 2'd1) begin errors++; $display("FAIL pop1_count got %0d want 1", HIST_COUNT); end
        cyc(0, 8'h00, 0, 0, 0, 1, 0, 0);
        checks++; if (ADL_BUS !== 8'h34) begin errors++; $display("FAIL pop1_data got %h want 34", ADL_BUS); end
        cyc(0, 8'h00, 0, 0, 1, 0, 0, 0);
        cyc(0, 8'h00, 0, 0, 0, 1, 0, 0);
        checks++; if (ADL_BUS !== 8'h12) begin errors++; $display("FAIL pop2_data got %h want 12", ADL_BUS); end
        cyc(0, 8'h00, 0, 0, 1, 0, 0, 0);
        checks++; if (RESTORE_ERR !== 1'b1) begin errors++; $display("FAIL empty_err got %b want 1", RESTORE_ERR); end
        checks++; if (HIST_COUNT !== 2'd0) begin errors++; $display("FAIL empty_count got %0d want 0", HIST_COUNT); end
        cyc(0, 8'h00, 0, 0, 0, 1, 0, 0);
        checks++; if (RESTORE_ERR !== 1'b0) begin errors++; $display("FAIL err_pulse got %b want 0", RESTORE_ERR); end
        checks++; if (ADL_BUS !== 8'h12) begin errors++; $display("FAIL empty_hold got %h want 12", ADL_BUS); end
    endtask

    task automatic test_load_restore;
        cyc(1, 8'hA5, 0, 1, 1, 0, 0, 0);
        checks++; if (HIST_COUNT !== 2'd1) begin errors++; $display("FAIL lr_count got %0d want 1", HIST_COUNT); end
        checks++; if (RESTORE_ERR !== 1'b0) begin errors++; $display("FAIL lr_err got %b want 0", RESTORE_ERR); end
        checks++; if (HOLD_V !== 1'b1) begin errors++; $display("FAIL lr_v got %b want 1", HOLD_V); end
        cyc(0, 8'h00, 0, 0, 0, 1, 0, 0);
        checks++; if (ADL_BUS !== 8'hA5) begin errors++; $display("FAIL lr_data got %h want a5", ADL_BUS); end
    endtask

`ifdef DECIMAL_ADJ_EN
    task automatic test_decimal;
        DAA = 1; ALU_HC = 0;
        cyc(1, 8'h0C, 0, 0, 0, 0, 0, 0);
        ALU_HC = 1;
        cyc(1, 8'h0F, 0, 0, 0, 1, 0, 0);
        checks++; if (ADL_BUS !== 8'h0C) begin errors++; $display("FAIL daa_none got %h want 0c", ADL_BUS); end
        DAA = 0; DSA = 1; ALU_HC = 1;
        cyc(1, 8'hF9, 0, 0, 0, 1, 0, 0);
        checks++; if (ADL_BUS !== 8'h15) begin errors++; $display("FAIL daa_hc got %h want 15", ADL_BUS); end
        DSA = 0; ALU_HC = 0;
        cyc(0, 8'h00, 0, 0, 0, 1, 0, 0);
        checks++; if (ADL_BUS !== 8'h99) begin errors++; $display("FAIL dsa_c got %h want 99", ADL_BUS); end
    endtask
`endif

    task automatic test_random;
        logic [9:0] hist[$];
        logic [9:0] e;
        logic [7:0] m_hold, m_adl, m_sb, old, d, cd;
        logic       m_c, m_v, m_err, ld, rs, c, v, adl, sbl, sbh;
        int         dec_mode;
        logic       hc;
        do_reset();
        m_hold = 0; m_c = 0; m_v = 0; m_err = 0; m_adl = 8'hFF; m_sb = 8'hFF;
        for (int n = 0; n < 300; n++) begin
            ld = ($urandom_range(0, 2) == 0); rs = ($urandom_range(0, 1) == 0);
            d = 8'($urandom); c = 1'($urandom); v = 1'($urandom);
            adl = 1'($urandom); sbl = 1'($urandom); sbh = 1'($urandom);
            dec_mode = 0; hc = 1'($urandom);
`ifdef DECIMAL_ADJ_EN
            dec_mode = $urandom_range(0, 3);
            DAA = dec_mode[0]; DSA = dec_mode[1]; ALU_HC = hc;
`endif
            cd = d;
            if (dec_mode == 1) cd = 8'((int'(d) + (hc ? 6 : 0) + (c ? 96 : 0)) % 256);
            if (dec_mode == 2) cd = 8'((int'(d) + 512 - (hc ? 0 : 6) - (c ? 0 : 96)) % 256);
            old = m_hold;
            m_err = rs && !ld && hist.size() == 0;
            if (ld) begin
                if (hist.size() == DEPTH) void'(hist.pop_front());
                hist.push_back({m_hold, m_c, m_v});
                m_hold = cd; m_c = c; m_v = v;
            end else if (rs && hist.size() > 0) begin
                e = hist.pop_back();
                {m_hold, m_c, m_v} = e;
            end
            if (adl) m_adl = old;
            if (sbl) m_sb = (m_sb & 8'h80) | (old & 8'h7F);
            if (sbh) m_sb = (m_sb & 8'h7F) | (old & 8'h80);
            cyc(ld, d, c, v, rs, adl, sbl, sbh);
            checks++; if (ADL_BUS !== m_adl) begin errors++; $display("FAIL rnd_adl step %0d got %h want %h", n, ADL_BUS, m_adl); end
            checks++; if (SB_BUS !== m_sb) begin errors++; $display("FAIL rnd_sb step %0d got %h want %h", n, SB_BUS, m_sb); end
            checks++; if ({HOLD_C, HOLD_V} !== {m_c, m_v}) begin errors++; $display("FAIL rnd_cv step %0d got %b want %b", n, {HOLD_C, HOLD_V}, {m_c, m_v}); end
            checks++; if (int'(HIST_COUNT) != hist.size()) begin errors++; $display("FAIL rnd_count step %0d got %0d want %0d", n, HIST_COUNT, hist.size()); end
            checks++; if (RESTORE_ERR !== m_err) begin errors++; $display("FAIL rnd_err step %0d got %b want %b", n, RESTORE_ERR, m_err); end
        end
`ifdef DECIMAL_ADJ_EN
        DAA = 0; DSA = 0; ALU_HC = 0;
`endif
    endtask

    initial begin
        test_reset();
        test_load_drive();
        test_sb_split();
        test_history();
        test_load_restore();
`ifdef DECIMAL_ADJ_EN
        test_decimal();
`endif
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
